mac_accumulator: RTL and testbench
==================================

# mac_accumulator

Accumulates a stream of signed 2·BIT-bit products from the signed multiplier stage into dot-product sums of LEN terms. Each finished sum is rounded, right-shifted and narrowed to OUT_W bits, then presented on a ready/valid output. The block sits directly downstream of the multiplier and consumes its registered product and valid strobe unchanged. The multiplier cannot be stalled, so this block never backpressures its input.

## Interface

- BIT, default 32: multiplier operand width. The product input is 2·BIT bits.
- LEN, default 16: products per sum. Must be ≥ 2.
- SHIFT, default 0: fractional bits removed from the sum at the output.
- OUT_W, default 32: output width.
- Derived localparam ACC_W = 2·BIT + $clog2(LEN). Internal sums are never allowed to wrap.

Ports:

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- prod_in_valid  in  1  product valid. Connects to the multiplier's data_out_valid.
- prod_in  in  2·BIT  signed product. Connects to the multiplier's C_out.
- acc_clear  in  1  synchronous restart of the current group.
- acc_out_valid  out  1  result valid.
- acc_out_ready  in  1  consumer accepts the result.
- acc_out  out  OUT_W  signed result.
- overrun  out  1  sticky flag: a result was dropped.
- sat  out  1  saturation occurred on the currently presented result.

## Operation

**FSM**
- States are IDLE (count = 0) and ACC (0 < count < LEN).
- IDLE → ACC on a valid product: acc ← sign-extended product, count ← 1.
- In ACC, each valid product does acc ← acc + product and count ← count + 1.
- Completion: when the LEN-th product is accepted, the full sum (acc + product) is written to register sum_r and the FSM returns to IDLE with count = 0.
- A product arriving on the very next cycle starts a new group without a gap.

**acc_clear**
- Discards the partial sum and sets count = 0.
- If prod_in_valid is high in the same cycle, that product becomes element 1 of a new group.
- Does not affect a result already in sum_r or in the output register.
- Clears overrun.

**Quantize stage (one cycle)**
- If SHIFT > 0, add 2^(SHIFT−1) to sum_r (round half up), then arithmetic right shift by SHIFT.
- Narrow to OUT_W bits as described under Configuration.

**Output register**
- Loaded when a quantized result is ready and either acc_out_valid = 0 or acc_out_ready = 1 in that cycle.
- Otherwise the new result is dropped, overrun ← 1, and the held result stays stable.
- acc_out_valid falls on the handshake cycle (valid & ready) unless a new result loads in that same cycle.
- acc_out and sat hold stable while acc_out_valid = 1 and acc_out_ready = 0.

**Reset**
- rst_n low at any time, including mid-group, forces acc, count, sum_r, the stage valids, acc_out, acc_out_valid, overrun and sat to 0, and the FSM to IDLE.
- The partial group is lost.

## Timing

- The last product of a group is accepted at edge k. sum_r is valid after edge k; acc_out_valid is high after edge k+1.
- Latency from last product to result is 2 cycles.
- Throughput is one product per cycle, sustained indefinitely while the consumer keeps up.
- Gaps in prod_in_valid are allowed anywhere; only valid cycles count toward LEN.
- Minimum spacing between results is LEN cycles.
- A consumer that drops acc_out_ready for fewer than LEN cycles never causes overrun.

## Configuration

Macro MAC_SAT_EN.

- Defined: the narrowed value is clamped to [−2^(OUT_W−1), 2^(OUT_W−1)−1]. sat = 1 on the result that was clamped.
- Undefined: the narrowed value is the low OUT_W bits of the shifted sum (two's-complement wrap). sat is tied to 0.

## Test plan

1. LEN=4, SHIFT=0: products 1, 2, 3, 4 on consecutive cycles with ready=1 → acc_out=10 and acc_out_valid high exactly 2 cycles after the 4th valid, for one cycle.
2. LEN=4, gapped valids with products −5, 3, −7, 1 and idle cycles between them → acc_out=0xFFFFFFF8 (−8). The next group starting immediately after the last product yields its own independent sum.
3. LEN=2, SHIFT=4:
   - products 20, 4 (sum 24) → acc_out=2;
   - products −20, −4 (sum −24) → acc_out=0xFFFFFFFF (−1).
4. LEN=4, SHIFT=0, OUT_W=32, four products of 2^30:
   - with MAC_SAT_EN → acc_out=0x7FFFFFFF, sat=1;
   - without it → acc_out=0x00000000, sat=0.
5. LEN=4: hold acc_out_ready=0 across two group completions.
   - The first result is held stable and overrun goes to 1.
   - Raising ready for one cycle accepts the first result and valid falls.
   - acc_clear returns overrun to 0.
6. Reset and clear mid-group:
   - Assert rst_n=0 after 2 of 4 products → all outputs 0. Four fresh products 1, 1, 1, 1 → 4.
   - Pulse acc_clear together with valid product 9 after 3 partial products, then send 1, 1, 1 → 12.

Source files
------------

// File: rtl/mac_accumulator.sv
// ============================================================================
// mac_accumulator : groups LEN signed products into dot-product sums, then
// rounds, shifts and narrows each sum onto a ready/valid output.
// Optional MAC_SAT_EN clamps instead of wrapping.   Rev 1.0
// ============================================================================
`default_nettype none

module mac_accumulator #(
    parameter int BIT   = 32,
    parameter int LEN   = 16,
    parameter int SHIFT = 0,
    parameter int OUT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               prod_in_valid,
    input  logic [2*BIT-1:0]   prod_in,
    input  logic               acc_clear,
    output logic               acc_out_valid,
    input  logic               acc_out_ready,
    output logic [OUT_W-1:0]   acc_out,
    output logic               overrun,
    output logic               sat
);

    localparam int ACC_W = 2*BIT + $clog2(LEN);
    localparam int CNT_W = $clog2(LEN);
    localparam int QW    = ACC_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, ACC = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [ACC_W-1:0]        sum_q, sum_d;
    logic                    sum_vld_q, sum_vld_d;
    logic [OUT_W-1:0]        out_q;
    logic                    out_vld_q;
    logic                    overrun_q;
    logic                    sat_q;

    logic [ACC_W-1:0]        prod_ext;
    logic signed [QW-1:0]    sum_wide;
    logic signed [QW-1:0]    shifted;
    logic [OUT_W-1:0]        q_val;
    logic                    q_sat;
    logic                    load;

    assign prod_ext = {{(ACC_W-2*BIT){prod_in[2*BIT-1]}}, prod_in};

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        count_d   = count_q;
        sum_d     = sum_q;
        sum_vld_d = 1'b0;
        if (acc_clear) begin
            state_d = IDLE;
            acc_d   = '0;
            count_d = '0;
            // LEN >= 2, so a product taken with a clear can never finish a group
            if (prod_in_valid) begin
                state_d = ACC;
                acc_d   = prod_ext;
                count_d = CNT_W'(1);
            end
        end else if (prod_in_valid) begin
            case (state_q)
                IDLE: begin
                    state_d = ACC;
                    acc_d   = prod_ext;
                    count_d = CNT_W'(1);
                end
                ACC: begin
                    if (count_q == LAST_CNT) begin
                        sum_d     = acc_q + prod_ext;
                        sum_vld_d = 1'b1;
                        acc_d     = '0;
                        count_d   = '0;
                        state_d   = IDLE;
                    end else begin
                        acc_d   = acc_q + prod_ext;
                        count_d = count_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            count_q   <= '0;
            sum_q     <= '0;
            sum_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            sum_q     <= sum_d;
            sum_vld_q <= sum_vld_d;
        end
    end

    // One guard bit keeps the rounding increment from wrapping the sum.
    assign sum_wide = {sum_q[ACC_W-1], sum_q};

    if (SHIFT > 0) begin : g_round
        logic signed [QW-1:0] rnd;
        assign rnd     = sum_wide + (QW'(1) <<< (SHIFT - 1));
        assign shifted = rnd >>> SHIFT;
    end else begin : g_noround
        assign shifted = sum_wide;
    end

    if (QW > OUT_W) begin : g_narrow
`ifdef MAC_SAT_EN
        logic hi_ok;
        assign hi_ok = (&shifted[QW-1:OUT_W-1]) | ~(|shifted[QW-1:OUT_W-1]);
        assign q_val = hi_ok ? shifted[OUT_W-1:0]
                     : (shifted[QW-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                      : {1'b0, {(OUT_W-1){1'b1}}});
        assign q_sat = ~hi_ok;
`else
        logic unused_hi;
        assign unused_hi = ^shifted[QW-1:OUT_W];
        assign q_val     = shifted[OUT_W-1:0];
        assign q_sat     = 1'b0;
`endif
    end else begin : g_widen
        assign q_val = OUT_W'(shifted);
        assign q_sat = 1'b0;
    end

    assign load = sum_vld_q & (~out_vld_q | acc_out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            out_vld_q <= 1'b0;
            overrun_q <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            if (load) begin
                out_q     <= q_val;
                sat_q     <= q_sat;
                out_vld_q <= 1'b1;
            end else if (acc_out_ready) begin
                out_vld_q <= 1'b0;
            end
            // A drop in the same cycle as a clear still gets reported.
            if (sum_vld_q && !load) begin
                overrun_q <= 1'b1;
            end else if (acc_clear) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign acc_out_valid = out_vld_q;
    assign acc_out       = out_q;
    assign overrun       = overrun_q;
    assign sat           = sat_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_accumulator.sv
// ============================================================================
// tb_mac_accumulator : directed self-checking bench for mac_accumulator.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mac_accumulator;

    logic        clk;
    logic        rst_n;
    logic        prod_in_valid;
    logic [63:0] prod_in;
    logic        acc_clear;
    logic        acc_out_ready;

    logic        a_valid, a_overrun, a_sat;
    logic [31:0] a_out;
    logic        b_valid, b_overrun, b_sat;
    logic [31:0] b_out;

    int n_chk;
    int n_err;

    mac_accumulator #(.BIT(32), .LEN(4), .SHIFT(0), .OUT_W(32)) u_dut_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .prod_in_valid (prod_in_valid),
        .prod_in       (prod_in),
        .acc_clear     (acc_clear),
        .acc_out_valid (a_valid),
        .acc_out_ready (acc_out_ready),
        .acc_out       (a_out),
        .overrun       (a_overrun),
        .sat           (a_sat)
    );

    mac_accumulator #(.BIT(32), .LEN(2), .SHIFT(4), .OUT_W(32)) u_dut_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .prod_in_valid (prod_in_valid),
        .prod_in       (prod_in),
        .acc_clear     (acc_clear),
        .acc_out_valid (b_valid),
        .acc_out_ready (acc_out_ready),
        .acc_out       (b_out),
        .overrun       (b_overrun),
        .sat           (b_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic signed [63:0] p);
        prod_in_valid = 1'b1;
        prod_in       = p;
        @(posedge clk);
        #1;
        prod_in_valid = 1'b0;
        prod_in       = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset;
        rst_n         = 1'b0;
        prod_in_valid = 1'b0;
        prod_in       = '0;
        acc_clear     = 1'b0;
        acc_out_ready = 1'b1;
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        do_reset();
        chk("rst_valid", a_valid, 0);
        chk("rst_out", a_out, 0);
        chk("rst_overrun", a_overrun, 0);

        // 1: consecutive 1..4, two-cycle latency, one-cycle valid
        send(1); send(2); send(3); send(4);
        chk("t1_early", a_valid, 0);
        idle(1);
        chk("t1_valid", a_valid, 1);
        chk("t1_out", a_out, 10);
        idle(1);
        chk("t1_drop", a_valid, 0);

        // 2: gapped negatives, back-to-back next group
        do_reset();
        send(-5); idle(2); send(3); idle(1); send(-7); idle(3); send(1);
        send(10);
        chk("t2_valid", a_valid, 1);
        chk("t2_out", a_out, 32'hFFFFFFF8);
        send(20);
        chk("t2_taken", a_valid, 0);
        send(30); send(40);
        idle(1);
        chk("t2_next", a_out, 100);

        // 3: LEN=2, SHIFT=4 rounding
        do_reset();
        send(20); send(4);
        idle(1);
        chk("t3_pos_valid", b_valid, 1);
        chk("t3_pos", b_out, 2);
        do_reset();
        send(-20); send(-4);
        idle(1);
        chk("t3_neg", b_out, 32'hFFFFFFFF);

        // 4: overflow of the 32-bit output
        do_reset();
        repeat (4) send(64'sd1 <<< 30);
        idle(1);
`ifdef MAC_SAT_EN
        chk("t4_out", a_out, 32'h7FFFFFFF);
        chk("t4_sat", a_sat, 1);
`else
        chk("t4_out", a_out, 32'h00000000);
        chk("t4_sat", a_sat, 0);
`endif

        // 5: consumer stalls over two completions
        do_reset();
        acc_out_ready = 1'b0;
        send(1); send(1); send(1); send(1);
        idle(1);
        chk("t5_first", a_out, 4);
        chk("t5_no_ovr", a_overrun, 0);
        send(2); send(2); send(2); send(2);
        idle(2);
        chk("t5_held", a_out, 4);
        chk("t5_held_vld", a_valid, 1);
        chk("t5_ovr", a_overrun, 1);
        acc_out_ready = 1'b1;
        idle(1);
        acc_out_ready = 1'b0;
        chk("t5_accept", a_valid, 0);
        chk("t5_ovr_sticky", a_overrun, 1);
        acc_clear = 1'b1;
        idle(1);
        acc_clear = 1'b0;
        chk("t5_clr_ovr", a_overrun, 0);

        // 6: async reset mid-group, then clear with a coincident product
        do_reset();
        send(5); send(6);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", a_valid, 0);
        chk("t6_rst_out", a_out, 0);
        chk("t6_rst_sat", a_sat, 0);
        #2;
        rst_n = 1'b1;
        idle(1);
        send(1); send(1); send(1); send(1);
        idle(1);
        chk("t6_fresh", a_out, 4);
        send(2); send(2); send(2);
        acc_clear = 1'b1;
        send(9);
        acc_clear = 1'b0;
        send(1); send(1); send(1);
        idle(1);
        chk("t6_clear_vld", a_valid, 1);
        chk("t6_clear", a_out, 12);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
